// File: rtl/rom_fill_scheduler.sv
// Streams a fixed ROM value segment into per-channel value FIFOs, one address per cycle, round-robin.
// Optional FETCH_SKIP_FULL_EN: work-conserving arbitration that skips full channels; default is strict order.
module rom_fill_scheduler #(
  parameter int CHANNEL_NUM = 4,
  parameter int ADDR_W      = 16,
  parameter int VAL_START   = 0,
  parameter int VAL_COUNT   = 3971
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic [ADDR_W-1:0]      rom_addr,
  input  logic [7:0]             rom_data,
  input  logic [CHANNEL_NUM-1:0] fifo_full,
  output logic [CHANNEL_NUM-1:0] fifo_wr,
  output logic [7:0]             fifo_din,
  output logic                   busy,
  output logic                   done
);

  localparam int PW = $clog2(CHANNEL_NUM);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t                 state, state_nxt;
  logic [ADDR_W-1:0]      addr;
  logic [ADDR_W:0]        remaining;
  logic [PW-1:0]          rr_ptr;
  logic [CHANNEL_NUM-1:0] eligible;
  logic [CHANNEL_NUM-1:0] grant;
  logic                   gnt_vld;
  logic [PW-1:0]          gnt_idx;
  logic                   issue;
  logic                   last_issue;

  // The channel written this cycle was granted last cycle; its full flag has not caught up yet.
  assign eligible = ~fifo_full & ~fifo_wr;

`ifdef FETCH_SKIP_FULL_EN
  logic [PW-1:0] cand;

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = rr_ptr;
    cand    = rr_ptr;
    for (int i = 0; i < CHANNEL_NUM; i++) begin
      cand = PW'((int'(rr_ptr) + i) % CHANNEL_NUM);
      if (!gnt_vld && eligible[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end
`else
  always_comb begin
    gnt_idx = rr_ptr;
    gnt_vld = eligible[rr_ptr];
  end
`endif

  assign issue      = (state == ISSUE) && gnt_vld;
  assign last_issue = issue && (remaining == (ADDR_W+1)'(1));
  assign grant      = issue ? (CHANNEL_NUM'(1) << gnt_idx) : '0;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ISSUE;
      ISSUE:   if (last_issue) state_nxt = DRAIN;
      DRAIN:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      addr      <= ADDR_W'(VAL_START);
      remaining <= (ADDR_W+1)'(VAL_COUNT);
      rr_ptr    <= '0;
      fifo_wr   <= '0;
    end else begin
      state   <= state_nxt;
      fifo_wr <= grant;
      if (state == IDLE) begin
        addr      <= ADDR_W'(VAL_START);
        remaining <= (ADDR_W+1)'(VAL_COUNT);
        rr_ptr    <= '0;
      end else if (issue) begin
        remaining <= remaining - (ADDR_W+1)'(1);
        // Hold on the final address so the segment end never wraps the counter.
        if (!last_issue) addr <= addr + ADDR_W'(1);
        rr_ptr <= (gnt_idx == PW'(CHANNEL_NUM - 1)) ? '0 : gnt_idx + PW'(1);
      end
    end
  end

  assign rom_addr = addr;
  assign fifo_din = rom_data;
  assign busy     = (state == ISSUE) || (state == DRAIN);
  assign done     = (state == DONE);

endmodule

// File: tb/tb_rom_fill_scheduler.sv
// Scoreboard bench for rom_fill_scheduler: expected (channel, byte) pairs queued at start, popped on each FIFO write.
module tb_rom_fill_scheduler;
  localparam int CN = 4;
  localparam int AW = 16;
  localparam int VC = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] rom_addr;
  logic [7:0]    rom_data;
  logic [CN-1:0] fifo_full;
  logic [CN-1:0] fifo_wr;
  logic [7:0]    fifo_din;
  logic          busy;
  logic          done;

  typedef struct {
    int         ch;
    logic [7:0] dat;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_wr_cyc = -10;
  int   skip_ch[8] = '{0, 2, 3, 0, 2, 3, 0, 2};

  always #5 clk = ~clk;

  rom_fill_scheduler #(
    .CHANNEL_NUM(CN), .ADDR_W(AW), .VAL_START(0), .VAL_COUNT(VC)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .rom_addr(rom_addr), .rom_data(rom_data),
    .fifo_full(fifo_full), .fifo_wr(fifo_wr), .fifo_din(fifo_din), .busy(busy), .done(done)
  );

  function automatic logic [7:0] rom_val(input logic [AW-1:0] a);
    return (a[7:0] * 8'd29) ^ 8'h5a;
  endfunction

  always @(posedge clk) rom_data <= rom_val(rom_addr);
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (fifo_wr !== '0) begin
      last_wr_cyc = cyc;
      if (sb.size() == 0) begin
        check("wr_unexpected", 32'(fifo_wr), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("wr_ch", 32'(fifo_wr), 32'(1) << mon_e.ch);
        check("wr_dat", 32'(fifo_din), 32'(mon_e.dat));
      end
    end
  end

  task automatic push_exp(input int ch, input int k);
    exp_t e;
    e.ch  = ch;
    e.dat = rom_val(AW'(k));
    sb.push_back(e);
  endtask

  // Returns at the falling edge of the first issue cycle.
  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_done_lag"}, 32'(cyc - last_wr_cyc), 32'd1);
    check({tag, "_busy_low"}, 32'(busy), 32'd0);
    check({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    start = 1'b0;
    fifo_full = '0;
    repeat (2) @(negedge clk);
    check("rst_addr", 32'(rom_addr), 32'd0);
    check("rst_wr", 32'(fifo_wr), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_done", 32'(done), 32'd0);
    end

    // Unobstructed transfer: strict round robin order.
    for (int k = 0; k < VC; k++) push_exp(k % CN, k);
    pulse_start();
    for (int k = 0; k < VC; k++) begin
      check("basic_addr", 32'(rom_addr), 32'(k));
      check("basic_busy", 32'(busy), 32'd1);
      @(negedge clk);
    end
    wait_done("basic");

    // Channel 1 permanently full.
    fifo_full = 4'b0010;
`ifdef FETCH_SKIP_FULL_EN
    for (int k = 0; k < VC; k++) push_exp(skip_ch[k], k);
    pulse_start();
    for (int k = 0; k < VC; k++) begin
      check("skip_addr", 32'(rom_addr), 32'(k));
      @(negedge clk);
    end
`else
    for (int k = 0; k < VC; k++) push_exp(k % CN, k);
    pulse_start();
    check("strict_addr0", 32'(rom_addr), 32'd0);
    @(negedge clk);
    check("strict_stall_addr", 32'(rom_addr), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("strict_stall_addr", 32'(rom_addr), 32'd1);
      check("strict_stall_wr", 32'(fifo_wr), 32'd0);
      check("strict_stall_busy", 32'(busy), 32'd1);
    end
    fifo_full = '0;
`endif
    wait_done("full1");
    fifo_full = '0;

    // All channels full for five cycles mid-transfer.
    for (int k = 0; k < VC; k++) push_exp(k % CN, k);
    pulse_start();
    repeat (3) @(negedge clk);
    fifo_full = '1;
    #1 check("allfull_addr", 32'(rom_addr), 32'd3);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("allfull_addr", 32'(rom_addr), 32'd3);
      check("allfull_wr", 32'(fifo_wr), 32'd0);
      check("allfull_busy", 32'(busy), 32'd1);
    end
    @(negedge clk);
    fifo_full = '0;
    wait_done("allfull");

    // Reset in the middle of a transfer drops the in-flight byte.
    for (int k = 0; k < VC; k++) push_exp(k % CN, k);
    pulse_start();
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_addr", 32'(rom_addr), 32'd0);
    check("midrst_wr", 32'(fifo_wr), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    sb.delete();
    @(negedge clk);
    check("midrst_wr_next", 32'(fifo_wr), 32'd0);
    #2 rst = 1'b0;
    @(negedge clk);
    check("postrst_busy", 32'(busy), 32'd0);

    // Restart from VAL_START; a start pulse during busy is ignored.
    for (int k = 0; k < VC; k++) push_exp(k % CN, k);
    pulse_start();
    for (int k = 0; k < VC; k++) begin
      check("restart_addr", 32'(rom_addr), 32'(k));
      start = (k == 2);
      @(negedge clk);
    end
    start = 1'b0;
    wait_done("restart");
    repeat (5) @(negedge clk);
    check("restart_ignored_busy", 32'(busy), 32'd0);
    check("restart_ignored_sb", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
